// File: rtl/core_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_irq_ctrl_pkg
//
// Shared constants, types and helpers for the fast-interrupt controller.
//   NumFastIrqs      : width of the core's fast-interrupt input vector
//   FastIrqIdBase    : core interrupt ID of fast line 0
//   Irq*Offset       : byte offsets of the controller's registers
//   reg_sel_e        : decoded register select
//   decode_offset()  : maps an 8-bit byte offset onto reg_sel_e
//   be_to_mask()     : expands 4 byte enables into a 32-bit bit mask
// -----------------------------------------------------------------------------
package core_irq_ctrl_pkg;

  localparam int unsigned NumFastIrqs   = 16;
  localparam int unsigned FastIrqIdBase = 16;

  localparam logic [7:0] IrqPendingOffset = 8'h00;
  localparam logic [7:0] IrqEnableOffset  = 8'h04;
  localparam logic [7:0] IrqEdgeOffset    = 8'h08;
  localparam logic [7:0] IrqActiveOffset  = 8'h0C;

  typedef enum logic [2:0] {
    RegPending,
    RegEnable,
    RegEdge,
    RegActive,
    RegNone
  } reg_sel_e;

  // Only exact word offsets select a register; anything else (including
  // misaligned offsets inside a word) is reported as an error.
  function automatic reg_sel_e decode_offset(input logic [7:0] offset);
    reg_sel_e sel;
    case (offset)
      IrqPendingOffset: sel = RegPending;
      IrqEnableOffset:  sel = RegEnable;
      IrqEdgeOffset:    sel = RegEdge;
      IrqActiveOffset:  sel = RegActive;
      default:          sel = RegNone;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/core_irq_ctrl_sync.sv
// -----------------------------------------------------------------------------
// core_irq_sync
//
// Parameterised-width two-flop synchronizer used to bring asynchronous
// interrupt lines into the clk_i domain. Both stages reset to 0.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : raw (possibly asynchronous) inputs, Width bits
//   q_o    : synchronized outputs, two clk_i cycles later
// -----------------------------------------------------------------------------
module core_irq_sync #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_d, sync1_q;
  logic [Width-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/core_irq_ctrl.sv
// -----------------------------------------------------------------------------
// core_irq_ctrl
//
// Fast-interrupt controller placed directly in front of the core. Each of the
// NumIrqs peripheral lines is captured either as an edge-latched pending bit
// (cleared by software W1C or by the core's acknowledge) or as a level bit
// that simply mirrors the registered line. Pending bits are masked by ENABLE
// and drive the core's fast interrupt inputs (core IDs 16..31).
//
// Register map (byte offset in reg_addr_i[7:0]):
//   0x00 PENDING  RW1C (edge lines only)
//   0x04 ENABLE   RW
//   0x08 EDGE     RW   1 = edge-triggered, 0 = level
//   0x0C ACTIVE   RO   PENDING & ENABLE
//   other         write ignored, read 0, err = 1
//
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   irqs_i            : raw peripheral interrupt lines (NumIrqs)
//   irq_fast_o        : to core fast interrupts (16, bits >= NumIrqs are 0)
//   irq_ack_i/irq_id_i: core acknowledge strobe and acknowledged ID
//   reg_*             : single-cycle OBI register port; gnt = req, response
//                       (rvalid/rdata/err) one cycle after the request
//
// Build option:
//   CORE_IRQ_SYNC_EN  : when defined, irqs_i passes through a 2-flop
//                       synchronizer (core_irq_sync) so lines may come from
//                       other clock domains; line-to-output latency becomes
//                       3 cycles instead of 1.
// -----------------------------------------------------------------------------
module core_irq_ctrl
  import core_irq_ctrl_pkg::*;
#(
  parameter int unsigned NumIrqs = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIrqs-1:0] irqs_i,
  output logic [15:0]        irq_fast_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_id_i,
  input  logic               reg_req_i,
  output logic               reg_gnt_o,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_be_i,
  input  logic [31:0]        reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic               reg_rvalid_o,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_err_o
);

  // ---------------------------------------------------------------------------
  // Line conditioning
  // ---------------------------------------------------------------------------
  logic [NumIrqs-1:0] line;

`ifdef CORE_IRQ_SYNC_EN
  core_irq_sync #(
    .Width(NumIrqs)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (irqs_i),
    .q_o   (line)
  );
`else
  assign line = irqs_i;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NumIrqs-1:0] pending_d, pending_q;
  logic [NumIrqs-1:0] enable_d,  enable_q;
  logic [NumIrqs-1:0] edge_d,    edge_q;
  logic [NumIrqs-1:0] prev_d,    prev_q;
  logic               rvalid_d,  rvalid_q;
  logic [31:0]        rdata_d,   rdata_q;
  logic               err_d,     err_q;

  // ---------------------------------------------------------------------------
  // Register port decode
  // ---------------------------------------------------------------------------
  reg_sel_e           reg_sel;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        be_mask;
  logic [NumIrqs-1:0] wr_mask;
  logic [NumIrqs-1:0] wr_bits;

  assign reg_sel = decode_offset(reg_addr_i[7:0]);
  assign wr_en   = reg_req_i & reg_we_i;
  assign rd_en   = reg_req_i & ~reg_we_i;
  assign be_mask = be_to_mask(reg_be_i);
  assign wr_mask = be_mask[NumIrqs-1:0];
  assign wr_bits = reg_wdata_i[NumIrqs-1:0] & wr_mask;

  // Upper address/data bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{reg_addr_i[31:8], reg_wdata_i, be_mask};

  // ---------------------------------------------------------------------------
  // Acknowledge decode: one-hot clear request for the acknowledged line.
  // IDs outside FastIrqIdBase..FastIrqIdBase+NumIrqs-1 match nothing.
  // ---------------------------------------------------------------------------
  logic [NumIrqs-1:0] ack_clr;

  always_comb begin
    ack_clr = '0;
    if (irq_ack_i) begin
      for (int i = 0; i < int'(NumIrqs); i++) begin
        if (irq_id_i == 5'(FastIrqIdBase + i)) begin
          ack_clr[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for pending / enable / edge / prev.
  // Edge lines: a rise always wins over W1C or ack in the same cycle; W1C and
  // ack together simply clear once. Level lines ignore both and follow the
  // line. The mode used is the registered EDGE value, so an EDGE write takes
  // effect from the following cycle. prev tracks the line in every mode so
  // switching to edge mode never manufactures a rise.
  // ---------------------------------------------------------------------------
  logic [NumIrqs-1:0] rise;
  logic [NumIrqs-1:0] w1c_clr;
  logic [NumIrqs-1:0] clr;

  always_comb begin
    rise    = line & ~prev_q;
    w1c_clr = '0;
    if (wr_en && (reg_sel == RegPending)) begin
      w1c_clr = wr_bits;
    end
    clr       = w1c_clr | ack_clr;
    pending_d = (edge_q & (rise | (pending_q & ~clr))) | (~edge_q & line);
    prev_d    = line;

    enable_d = enable_q;
    if (wr_en && (reg_sel == RegEnable)) begin
      enable_d = (enable_q & ~wr_mask) | wr_bits;
    end

    edge_d = edge_q;
    if (wr_en && (reg_sel == RegEdge)) begin
      edge_d = (edge_q & ~wr_mask) | wr_bits;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path. Reads sample the pre-edge register state of the request
  // cycle; writes return rdata 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid_d = reg_req_i;
    err_d    = reg_req_i && (reg_sel == RegNone);
    rdata_d  = '0;
    if (rd_en) begin
      case (reg_sel)
        RegPending: rdata_d = 32'(pending_q);
        RegEnable:  rdata_d = 32'(enable_q);
        RegEdge:    rdata_d = 32'(edge_q);
        RegActive:  rdata_d = 32'(pending_q & enable_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      prev_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      prev_q    <= prev_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    irq_fast_o              = '0;
    irq_fast_o[NumIrqs-1:0] = pending_q & enable_q;
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;

endmodule

// File: doc/core_irq_ctrl.md
# core_irq_ctrl

Fast-interrupt controller sitting directly upstream of the core wrapper. It captures the 16 peripheral interrupt lines as edge-latched or level pending bits and masks them with a software-programmable enable. It drives the core's 16 fast-interrupt inputs and auto-clears edge-pending bits on the core's interrupt acknowledge. Software configures it through a single-cycle OBI register port on the peripheral crossbar.

## Interface
- `NumIrqs`, default 16: number of interrupt lines; legal range 1..16.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `irqs_i`  in  NumIrqs  raw peripheral interrupt lines.
- `irq_fast_o`  out  16  to core fast-interrupt inputs (core irq IDs 16..31); bits ≥ NumIrqs tied 0.
- `irq_ack_i`  in  1  core acknowledge strobe, one cycle.
- `irq_id_i`  in  5  ID of the acknowledged interrupt.
- `reg_req_i`  in  1  OBI request.
- `reg_gnt_o`  out  1  OBI grant.
- `reg_we_i`  in  1  write enable.
- `reg_be_i`  in  4  byte enables.
- `reg_addr_i`  in  32  byte address; only [7:0] decoded.
- `reg_wdata_i`  in  32  write data.
- `reg_rvalid_o`  out  1  response valid.
- `reg_rdata_o`  out  32  read data.
- `reg_err_o`  out  1  response error.

## Operation
- Registers, offset in `reg_addr_i[7:0]`, bits [NumIrqs-1:0] live, others read 0:
  - 0x00 PENDING: RW1C, edge bits only; writes to level bits ignored.
  - 0x04 ENABLE: RW.
  - 0x08 EDGE: RW; 1 = edge-triggered, 0 = level.
  - 0x0C ACTIVE: RO, = PENDING & ENABLE; writes ignored, no error.
- Any other offset: write ignored; rdata 0; err 1.
- Byte enables honoured per byte on RW/RW1C writes.
- Edge mode:
  - `prev_q` holds last sampled line.
  - Rise = line & ~prev_q sets the pending bit.
- Level mode: pending bit = registered line value.
- `irq_fast_o[i]` = pending_q[i] & enable_q[i], combinational from flops.
- Acknowledge: when `irq_ack_i` is high and 16 ≤ `irq_id_i` < 16+NumIrqs, clear pending[id-16] if that line is in edge mode. Other IDs and level lines are ignored.
- Simultaneous events on one bit in the same cycle:
  - Rise beats W1C clear.
  - Rise beats ack clear.
  - W1C and ack together clear once.
- Changing EDGE for a line:
  - Takes effect next cycle.
  - Pending is re-evaluated under the new mode; no spurious edge is generated (prev_q keeps tracking).

## Timing
- Reset values: all registers 0, prev_q 0. Outputs: `irq_fast_o`=0, `reg_rvalid_o`=0, `reg_rdata_o`=0, `reg_err_o`=0.
- A line already high when reset releases is seen as an edge on the first cycle.
- `reg_gnt_o` = `reg_req_i`; every request is accepted in its cycle.
- Response timing:
  - `reg_rvalid_o` is high exactly one cycle after each accepted request.
  - `reg_rdata_o` and `reg_err_o` are registered and valid only in that cycle.
  - `reg_rdata_o` is 0 for writes.
- Writes take effect at the clock edge that accepts the request; a back-to-back read returns the new value.
- Read of PENDING/ACTIVE returns the pre-edge state of the request cycle.
- Line-to-output latency: line high in cycle N gives `irq_fast_o` high in N+1, for both modes.
- Ack in cycle N drops `irq_fast_o` in N+1, unless a new rise occurs in N.
- Reset mid-transaction:
  - Pending response is dropped; rvalid low.
  - All state is cleared asynchronously.

## Configuration
- `CORE_IRQ_SYNC_EN` defined:
  - Each `irqs_i` bit passes through a 2-flop synchronizer, reset 0, before edge/level logic.
  - Line-to-output latency becomes 3 cycles.
  - Supports lines from other clock domains.
- Undefined: lines used directly; latency 1 cycle; all lines must be synchronous to `clk_i`.

## Structure
- `croc_pkg` additions:
  - `NumFastIrqs` = 16.
  - Offsets `IrqPendingOffset`, `IrqEnableOffset`, `IrqEdgeOffset`, `IrqActiveOffset`.
  - `FastIrqIdBase` = 16.
- Sub-module `core_irq_sync`: parameterised-width 2-flop synchronizer with async active-low reset, instantiated only under the macro.

## Test plan
- ENABLE=0x0001, EDGE=0x0001; pulse `irqs_i[0]` one cycle at N:
  - `irq_fast_o`=0x0001 from N+1 and held.
  - Ack with id 16 gives `irq_fast_o`=0 next cycle.
- Level line 3 (EDGE bit 3 = 0, ENABLE=0x0008); hold `irqs_i[3]` high 5 cycles:
  - `irq_fast_o[3]` follows with 1-cycle lag.
  - Writing 0x0008 to PENDING has no effect.
- Edge line 2 pending; same cycle, W1C 0x0004 plus a new rise on line 2:
  - PENDING reads 0x0004 afterwards.
- Register port:
  - Write 0xFFFF_FFFF with be=0b0001 to ENABLE, then read: rdata 0x0000_00FF.
  - Read 0x10: rvalid with err=1, rdata 0.
  - gnt same cycle; rvalid exactly +1.
- Assert `rst_ni` low while line 0 is pending and a read is outstanding:
  - All outputs 0 immediately.
  - After release with line 0 held high, pending sets on the first cycle.
- With `CORE_IRQ_SYNC_EN`: line high at N gives `irq_fast_o` at N+3.
